// File: rtl/population_runner_pkg.sv
// +--------------------------------------------------------------------------+
// | population_runner_pkg                                                    |
// | Shared FSM state type and sizing helpers for the population runner.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package population_runner_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_RUN  = 3'd2,
        ST_NEXT = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    // Genes per genome: one per neuron input plus one per network output.
    function automatic int genes_count(input int neurons, input int conns, input int outs);
        return neurons * conns + outs;
    endfunction

    // Index width that never collapses to zero bits.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/population_runner_if.sv
// +--------------------------------------------------------------------------+
// | population_runner_if                                                     |
// | Controller, network I/O and RAM read port bundle.                        |
// | Optional macro: NET_SCORE_EN adds target/score/score_valid.              |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

interface population_runner_if #(
    parameter int INPUT_COUNT  = 1,
    parameter int OUTPUT_COUNT = 1,
    parameter int NETWORKS     = 16,
    parameter int GENE_W       = 16,
    parameter int ADDR_W       = 23
`ifdef NET_SCORE_EN
    ,
    parameter int SCORE_W      = 32
`endif
);
    import population_runner_pkg::*;

    localparam int NET_W = idx_w(NETWORKS);

    logic                    start;
    logic [63:0]             time_to_run;
    logic [ADDR_W-1:0]       base_addr;
    logic [INPUT_COUNT-1:0]  nin;
    logic [OUTPUT_COUNT-1:0] nout;
    logic                    busy;
    logic [NET_W-1:0]        active_network;
    logic                    network_finished;
    logic                    neurons_en;
    logic                    ram_req;
    logic [ADDR_W-1:0]       ram_addr;
    logic [GENE_W-1:0]       ram_rdata;
    logic                    ram_ready;
`ifdef NET_SCORE_EN
    logic [OUTPUT_COUNT-1:0] target;
    logic [SCORE_W-1:0]      score;
    logic                    score_valid;
`endif

`ifdef NET_SCORE_EN
    modport slave (
        input  start, time_to_run, base_addr, nin, ram_rdata, ram_ready, target,
        output nout, busy, active_network, network_finished, neurons_en,
               ram_req, ram_addr, score, score_valid
    );
    modport master (
        output start, time_to_run, base_addr, nin, ram_rdata, ram_ready, target,
        input  nout, busy, active_network, network_finished, neurons_en,
               ram_req, ram_addr, score, score_valid
    );
`else
    modport slave (
        input  start, time_to_run, base_addr, nin, ram_rdata, ram_ready,
        output nout, busy, active_network, network_finished, neurons_en,
               ram_req, ram_addr
    );
    modport master (
        output start, time_to_run, base_addr, nin, ram_rdata, ram_ready,
        input  nout, busy, active_network, network_finished, neurons_en,
               ram_req, ram_addr
    );
`endif

endinterface

`default_nettype wire

// File: rtl/population_runner_gene_fetch.sv
// +--------------------------------------------------------------------------+
// | gene_fetch                                                               |
// | Req/ready sequencer streaming one genome into the gene buffer.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module gene_fetch
    import population_runner_pkg::*;
#(
    parameter int GENES  = 5,
    parameter int GENE_W = 16,
    parameter int ADDR_W = 23,
    localparam int GI_W  = idx_w(GENES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic              load_base,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              ram_ready,
    input  logic [GENE_W-1:0] ram_rdata,
    output logic              ram_req,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              wr_en,
    output logic [GI_W-1:0]   wr_idx,
    output logic [GENE_W-1:0] wr_data,
    output logic              done
);

    logic              r_req;
    logic              r_gap;
    logic [ADDR_W-1:0] r_addr;
    logic [GI_W-1:0]   r_idx;

    logic w_accept;
    logic w_last;

    assign w_accept = r_req & ram_ready;
    assign w_last   = (r_idx == GI_W'(GENES - 1));

    // Genomes sit back to back, so the next network resumes at the running address.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req  <= 1'b0;
            r_gap  <= 1'b0;
            r_addr <= '0;
            r_idx  <= '0;
        end else if (go) begin
            r_req <= 1'b1;
            r_gap <= 1'b0;
            r_idx <= '0;
            if (load_base) begin
                r_addr <= base_addr;
            end
        end else if (w_accept) begin
            r_req  <= 1'b0;
            r_gap  <= ~w_last;
            r_addr <= r_addr + ADDR_W'(1);
            r_idx  <= w_last ? '0 : r_idx + GI_W'(1);
        end else if (r_gap) begin
            r_gap <= 1'b0;
            r_req <= 1'b1;
        end
    end

    assign ram_req  = r_req;
    assign ram_addr = r_addr;
    assign wr_en    = w_accept;
    assign wr_idx   = r_idx;
    assign wr_data  = ram_rdata;
    assign done     = w_accept & w_last;

endmodule

`default_nettype wire

// File: rtl/population_runner_neuron.sv
// +--------------------------------------------------------------------------+
// | neuron                                                                   |
// | Registered NAND neuron; output held at 0 while disabled.                 |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module neuron #(
    parameter int CONNECTIONS = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic [CONNECTIONS-1:0] dendrites,
    output logic                   axon
);

    // Clearing while disabled gives every network a clean start.
    always_ff @(posedge clk) begin
        if (rst || !en) begin
            axon <= 1'b0;
        end else begin
            axon <= ~&dendrites;
        end
    end

endmodule

`default_nettype wire

// File: rtl/population_runner.sv
// +--------------------------------------------------------------------------+
// | population_runner                                                        |
// | Loads each genome of a population from RAM, wires and runs its network.  |
// | Optional macro: NET_SCORE_EN enables per-network fitness scoring.        |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module population_runner
    import population_runner_pkg::*;
#(
    parameter int INPUT_COUNT  = 1,
    parameter int OUTPUT_COUNT = 1,
    parameter int NEURON_COUNT = 2,
    parameter int CONNECTIONS  = 2,
    parameter int NETWORKS     = 16,
    parameter int GENE_W       = 16,
    parameter int ADDR_W       = 23
`ifdef NET_SCORE_EN
    ,
    parameter int SCORE_W      = 32
`endif
) (
    input  logic                clk,
    input  logic                rst,
    population_runner_if.slave  bus
);

    localparam int GENES = genes_count(NEURON_COUNT, CONNECTIONS, OUTPUT_COUNT);
    localparam int NET_W = idx_w(NETWORKS);
    localparam int GI_W  = idx_w(GENES);
    localparam int SIG_N = INPUT_COUNT + NEURON_COUNT;
    localparam logic [NET_W-1:0] LAST_NET = NET_W'(NETWORKS - 1);

    state_t            r_state;
    logic [NET_W-1:0]  r_net;
    logic [63:0]       r_ttr;
    logic [63:0]       r_cyc;
    logic              r_busy;
    logic              r_fin;
    logic              r_en;
    logic [GENE_W-1:0] r_genes [GENES];

    logic                    w_fetch_go;
    logic                    w_load_base;
    logic                    w_req;
    logic [ADDR_W-1:0]       w_addr;
    logic                    w_wr_en;
    logic [GI_W-1:0]         w_wr_idx;
    logic [GENE_W-1:0]       w_wr_data;
    logic                    w_fetch_done;
    logic                    w_cyc_done;
    logic [NEURON_COUNT-1:0] w_neuron_out;
    logic [SIG_N-1:0]        w_sig;
    logic [CONNECTIONS-1:0]  w_neuron_in [NEURON_COUNT];
    logic [OUTPUT_COUNT-1:0] w_out_sel;
    logic [OUTPUT_COUNT-1:0] w_nout;

    assign w_load_base = (r_state == ST_IDLE);
    assign w_fetch_go  = (r_state == ST_IDLE && bus.start) ||
                         (r_state == ST_NEXT && r_net != LAST_NET);
    // A zero run length still runs for one cycle.
    assign w_cyc_done  = (r_cyc == ((r_ttr == 64'd0) ? 64'd0 : r_ttr - 64'd1));

    gene_fetch #(
        .GENES  (GENES),
        .GENE_W (GENE_W),
        .ADDR_W (ADDR_W)
    ) u_gene_fetch (
        .clk       (clk),
        .rst       (rst),
        .go        (w_fetch_go),
        .load_base (w_load_base),
        .base_addr (bus.base_addr),
        .ram_ready (bus.ram_ready),
        .ram_rdata (bus.ram_rdata),
        .ram_req   (w_req),
        .ram_addr  (w_addr),
        .wr_en     (w_wr_en),
        .wr_idx    (w_wr_idx),
        .wr_data   (w_wr_data),
        .done      (w_fetch_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_net   <= '0;
            r_ttr   <= '0;
            r_cyc   <= '0;
            r_busy  <= 1'b0;
            r_fin   <= 1'b0;
            r_en    <= 1'b0;
        end else begin
            r_fin <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_state <= ST_LOAD;
                        r_net   <= '0;
                        r_ttr   <= bus.time_to_run;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (w_fetch_done) begin
                        r_state <= ST_RUN;
                        r_en    <= 1'b1;
                        r_cyc   <= '0;
                    end
                end
                ST_RUN: begin
                    if (w_cyc_done) begin
                        r_state <= ST_NEXT;
                        r_en    <= 1'b0;
                    end else begin
                        r_cyc <= r_cyc + 64'd1;
                    end
                end
                ST_NEXT: begin
                    if (r_net == LAST_NET) begin
                        r_state <= ST_DONE;
                        r_fin   <= 1'b1;
                    end else begin
                        r_state <= ST_LOAD;
                        r_net   <= r_net + NET_W'(1);
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Fetch strobes only occur in LOAD, so RUN never disturbs the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < GENES; i++) begin
                r_genes[i] <= '0;
            end
        end else if (w_wr_en) begin
            r_genes[w_wr_idx] <= w_wr_data;
        end
    end

    // Out-of-range indices fall through to the constant-0 default.
    function automatic logic pick_sig(input logic [GENE_W-1:0] sel,
                                      input logic [SIG_N-1:0]  sig);
        logic v;
        v = 1'b0;
        for (int i = 0; i < SIG_N; i++) begin
            if (sel == GENE_W'(i)) begin
                v = sig[i];
            end
        end
        return v;
    endfunction

    assign w_sig = {w_neuron_out, bus.nin};

    always_comb begin
        w_out_sel = '0;
        for (int n = 0; n < NEURON_COUNT; n++) begin
            w_neuron_in[n] = '0;
            for (int k = 0; k < CONNECTIONS; k++) begin
                w_neuron_in[n][k] = pick_sig(r_genes[n*CONNECTIONS + k], w_sig);
            end
        end
        for (int o = 0; o < OUTPUT_COUNT; o++) begin
            w_out_sel[o] = pick_sig(r_genes[NEURON_COUNT*CONNECTIONS + o], w_sig);
        end
    end

    for (genvar n = 0; n < NEURON_COUNT; n++) begin : g_neuron
        neuron #(
            .CONNECTIONS (CONNECTIONS)
        ) u_neuron (
            .clk       (clk),
            .rst       (rst),
            .en        (r_en),
            .dendrites (w_neuron_in[n]),
            .axon      (w_neuron_out[n])
        );
    end

    assign w_nout = (r_state == ST_RUN) ? w_out_sel : '0;

`ifdef NET_SCORE_EN
    logic [SCORE_W-1:0] r_score_cnt;
    logic [SCORE_W-1:0] r_score;
    logic               r_score_valid;
    logic [SCORE_W-1:0] w_score_next;

    assign w_score_next = ((w_nout == bus.target) && (r_score_cnt != '1)) ?
                          r_score_cnt + SCORE_W'(1) : r_score_cnt;

    // The final RUN cycle's match is folded into the published value.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_score_cnt   <= '0;
            r_score       <= '0;
            r_score_valid <= 1'b0;
        end else begin
            r_score_valid <= 1'b0;
            if (r_state == ST_LOAD && w_fetch_done) begin
                r_score_cnt <= '0;
            end else if (r_state == ST_RUN) begin
                r_score_cnt <= w_score_next;
                if (w_cyc_done) begin
                    r_score       <= w_score_next;
                    r_score_valid <= 1'b1;
                end
            end
        end
    end

    assign bus.score       = r_score;
    assign bus.score_valid = r_score_valid;
`endif

    assign bus.nout             = w_nout;
    assign bus.busy             = r_busy;
    assign bus.active_network   = r_net;
    assign bus.network_finished = r_fin;
    assign bus.neurons_en       = r_en;
    assign bus.ram_req          = w_req;
    assign bus.ram_addr         = w_addr;

endmodule

`default_nettype wire

// File: tb/tb_population_runner.sv
// +--------------------------------------------------------------------------+
// | tb_population_runner                                                     |
// | Randomized self-checking bench with a cycle-level population model.      |
// | Optional macro: NET_SCORE_EN enables score checks.                       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_population_runner;
    import population_runner_pkg::*;

    localparam int IC    = 1;
    localparam int OC    = 1;
    localparam int NC    = 2;
    localparam int CN    = 2;
    localparam int NETS  = 2;
    localparam int GW    = 16;
    localparam int AW    = 23;
    localparam int SW    = 32;
    localparam int GENES = NC * CN + OC;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    population_runner_if #(
        .INPUT_COUNT (IC), .OUTPUT_COUNT (OC), .NETWORKS (NETS),
        .GENE_W (GW), .ADDR_W (AW)
`ifdef NET_SCORE_EN
        , .SCORE_W (SW)
`endif
    ) bus ();

    population_runner #(
        .INPUT_COUNT (IC), .OUTPUT_COUNT (OC), .NEURON_COUNT (NC),
        .CONNECTIONS (CN), .NETWORKS (NETS), .GENE_W (GW), .ADDR_W (AW)
`ifdef NET_SCORE_EN
        , .SCORE_W (SW)
`endif
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [GW-1:0] gtab [NETS][GENES];
    bit   [GW-1:0] ram  [bit [AW-1:0]];

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // sig[0..IC-1] = primary inputs, sig[IC+n] = neuron n, anything higher reads 0.
    function automatic bit sig_of(input logic [GW-1:0] idx, input bit [IC-1:0] nin_v,
                                  input bit [NC-1:0] nv);
        if (idx < IC)      return nin_v[idx];
        if (idx < IC + NC) return nv[idx - IC];
        return 1'b0;
    endfunction

    task automatic random_genes();
        for (int n = 0; n < NETS; n++)
            for (int g = 0; g < GENES; g++)
                gtab[n][g] = ($urandom_range(0, 7) == 0) ? 16'hFFFF
                                                          : 16'($urandom_range(0, IC + NC + 1));
    endtask

    task automatic idle_check(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            check_val("idle_busy", bus.busy, 0);
            check_val("idle_req", bus.ram_req, 0);
            check_val("idle_nout", bus.nout, 0);
        end
    endtask

    task automatic run_pop(input logic [AW-1:0] base, input logic [63:0] ttr, input int lat,
                           input bit abort_net1, input bit start_in_run, input bit score_case);
        int              t_len;
        int              l;
        int              score_m;
        logic [AW-1:0]   exp_a;
        bit   [NC-1:0]   nv;
        bit   [NC-1:0]   nv_n;
        bit   [IC-1:0]   nin_v;
        bit              exp_out;
        bit              a;
        t_len = (ttr == 64'd0) ? 1 : int'(ttr);
        for (int n = 0; n < NETS; n++)
            for (int g = 0; g < GENES; g++) begin
                exp_a = base + AW'(n * GENES + g);
                ram[exp_a] = gtab[n][g];
            end
        bus.start = 1'b1;
        bus.time_to_run = ttr;
        bus.base_addr = base;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("busy_after_start", bus.busy, 1);
        for (int net = 0; net < NETS; net++) begin
            for (int g = 0; g < GENES; g++) begin
                exp_a = base + AW'(net * GENES + g);
                check_val($sformatf("req n%0d g%0d", net, g), bus.ram_req, 1);
                check_val($sformatf("addr n%0d g%0d", net, g), bus.ram_addr, exp_a);
                check_val("load_active", bus.active_network, net);
                check_val("load_en", bus.neurons_en, 0);
                check_val("load_nout", bus.nout, 0);
                if (abort_net1 && net == 1 && g == 2) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    check_val("abort_req", bus.ram_req, 0);
                    check_val("abort_busy", bus.busy, 0);
                    check_val("abort_active", bus.active_network, 0);
                    check_val("abort_en", bus.neurons_en, 0);
                    return;
                end
                l = (lat > 0) ? lat : int'($urandom_range(1, 4));
                for (int w = 1; w < l; w++) begin
                    @(negedge clk);
                    check_val("req_hold", bus.ram_req, 1);
                    check_val("addr_stable", bus.ram_addr, exp_a);
                end
                bus.ram_rdata = ram.exists(bus.ram_addr) ? ram[bus.ram_addr] : '0;
                bus.ram_ready = 1'b1;
                @(negedge clk);
                bus.ram_ready = 1'b0;
                bus.ram_rdata = 16'($urandom);
                if (g != GENES - 1) begin
                    check_val("req_gap", bus.ram_req, 0);
                    @(negedge clk);
                end
            end
            nv = '0;
            score_m = 0;
            for (int c = 0; c < t_len; c++) begin
                nin_v = IC'($urandom);
                bus.nin = nin_v;
                bus.ram_ready = 1'($urandom);
                exp_out = sig_of(gtab[net][NC * CN], nin_v, nv);
`ifdef NET_SCORE_EN
                bus.target = score_case ? ((c == 1) ? ~exp_out : exp_out) : OC'($urandom);
                if (bus.target == exp_out) score_m++;
`endif
                if (start_in_run) begin
                    bus.start = 1'b1;
                    bus.base_addr = ~base;
                    bus.time_to_run = ttr + 64'd5;
                end
                #1;
                check_val("run_en", bus.neurons_en, 1);
                check_val("run_req", bus.ram_req, 0);
                check_val($sformatf("nout n%0d c%0d", net, c), bus.nout, exp_out);
                check_val("run_active", bus.active_network, net);
                check_val("run_fin", bus.network_finished, 0);
`ifdef NET_SCORE_EN
                check_val("run_score_valid", bus.score_valid, 0);
`endif
                for (int n = 0; n < NC; n++) begin
                    a = 1'b1;
                    for (int k = 0; k < CN; k++) a &= sig_of(gtab[net][n * CN + k], nin_v, nv);
                    nv_n[n] = ~a;
                end
                nv = nv_n;
                @(negedge clk);
                bus.start = 1'b0;
            end
            bus.ram_ready = 1'b0;
            bus.nin = IC'($urandom);
            #1;
            check_val("next_en", bus.neurons_en, 0);
            check_val("next_nout", bus.nout, 0);
            check_val("next_active", bus.active_network, net);
            check_val("next_busy", bus.busy, 1);
`ifdef NET_SCORE_EN
            check_val("next_score_valid", bus.score_valid, 1);
            check_val($sformatf("score n%0d", net), bus.score, score_m);
`endif
            @(negedge clk);
        end
        check_val("done_fin", bus.network_finished, 1);
        check_val("done_busy", bus.busy, 1);
        check_val("done_req", bus.ram_req, 0);
        if (start_in_run) bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        check_val("post_fin", bus.network_finished, 0);
        check_val("post_busy", bus.busy, 0);
        check_val("post_req", bus.ram_req, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.start = 1'b0;
        bus.time_to_run = '0;
        bus.base_addr = '0;
        bus.nin = '0;
        bus.ram_rdata = '0;
        bus.ram_ready = 1'b0;
`ifdef NET_SCORE_EN
        bus.target = '0;
`endif
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_req", bus.ram_req, 0);
        check_val("rst_addr", bus.ram_addr, 0);
        check_val("rst_en", bus.neurons_en, 0);
        check_val("rst_fin", bus.network_finished, 0);
        check_val("rst_active", bus.active_network, 0);
        check_val("rst_nout", bus.nout, 0);
        rst = 1'b0;
        idle_check(2);

        // Happy path and wiring: net 0 mirrors neuron 1, net 1 output gene out of range.
        gtab[0] = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd2};
        gtab[1] = '{16'd1, 16'd2, 16'd0, 16'd1, 16'hFFFF};
        run_pop(23'h100, 64'd4, 3, 1'b0, 1'b0, 1'b1);
        idle_check(2);

        // Reset in the middle of loading net 1, then a clean reload from base.
        random_genes();
        run_pop(23'h2000, 64'd3, 0, 1'b1, 1'b0, 1'b0);
        idle_check(2);
        run_pop(23'h2000, 64'd3, 0, 1'b0, 1'b0, 1'b0);
        idle_check(1);

        // Zero run length with start pulsed while busy.
        random_genes();
        run_pop(23'h40, 64'd0, 2, 1'b0, 1'b1, 1'b0);
        idle_check(1);

        // Address wrap across the top of the RAM.
        random_genes();
        run_pop(23'h7FFFFD, 64'd2, 1, 1'b0, 1'b0, 1'b0);
        idle_check(1);

        for (int r = 0; r < 4; r++) begin
            random_genes();
            run_pop(AW'($urandom), 64'($urandom_range(1, 6)), 0, 1'b0, 1'b0, 1'b0);
            idle_check(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
